qspi_bus_arbiter: RTL and testbench



---
 rtl/qspi_arb_pkg.sv | 34 +++
 rtl/qspi_pad_mux.sv | 49 ++++
 rtl/qspi_bus_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_qspi_bus_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI bus arbiter.
package qspi_arb_pkg;

  localparam int unsigned IO_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_e;

  localparam logic OWNER_FLASH = 1'b0;
  localparam logic OWNER_PSRAM = 1'b1;

  localparam logic            CE_IDLE     = 1'b1;
  localparam logic            SCLK_IDLE   = 1'b0;
  localparam logic [IO_W-1:0] IO_OE_IDLE  = 4'h0;
  localparam logic [IO_W-1:0] IO_OUT_IDLE = 4'h0;
  localparam logic [IO_W-1:0] IO_IN_IDLE  = 4'h0;

  // Pin-level QSPI signals driven by one requester.
  typedef struct packed {
    logic            ce_n;
    logic            sclk;
    logic [IO_W-1:0] io_out;
    logic [IO_W-1:0] io_oe;
  } qspi_pins_t;

  // Returns the winning requester id; prefer1 breaks a tie toward requester 1.
  function automatic logic arb_winner(input logic req0, input logic req1, input logic prefer1);
    return req1 & (~req0 | prefer1);
  endfunction

endpackage

// File: rtl/qspi_pad_mux.sv
// Combinational pad selection: routes the current owner onto the shared pads,
// otherwise parks the pads idle. The owner's CE pad is released as soon as its
// request drops so a late CE from the requester can never leak past release.
module qspi_pad_mux
  import qspi_arb_pkg::*;
(
  input  logic            active_i,
  input  logic            owner_i,
  input  logic            req0_i,
  input  logic            req1_i,
  input  qspi_pins_t      pins0_i,
  input  qspi_pins_t      pins1_i,
  input  logic [IO_W-1:0] pad_io_in_i,
  output logic            pad_ce0_n_o,
  output logic            pad_ce1_n_o,
  output logic            pad_sclk_o,
  output logic [IO_W-1:0] pad_io_out_o,
  output logic [IO_W-1:0] pad_io_oe_o,
  output logic [IO_W-1:0] io0_in_o,
  output logic [IO_W-1:0] io1_in_o
);

  // Owner/idle selection of every pad and of the read-data return paths.
  always_comb begin
    pad_ce0_n_o  = CE_IDLE;
    pad_ce1_n_o  = CE_IDLE;
    pad_sclk_o   = SCLK_IDLE;
    pad_io_out_o = IO_OUT_IDLE;
    pad_io_oe_o  = IO_OE_IDLE;
    io0_in_o     = IO_IN_IDLE;
    io1_in_o     = IO_IN_IDLE;
    if (active_i) begin
      if (owner_i == OWNER_FLASH) begin
        pad_ce0_n_o  = pins0_i.ce_n | ~req0_i;
        pad_sclk_o   = pins0_i.sclk;
        pad_io_out_o = pins0_i.io_out;
        pad_io_oe_o  = pins0_i.io_oe;
        io0_in_o     = pad_io_in_i;
      end else begin
        pad_ce1_n_o  = pins1_i.ce_n | ~req1_i;
        pad_sclk_o   = pins1_i.sclk;
        pad_io_out_o = pins1_i.io_out;
        pad_io_oe_o  = pins1_i.io_oe;
        io1_in_o     = pad_io_in_i;
      end
    end
  end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Two-requester QSPI pin-group arbiter (flash on CE0, PSRAM on CE1).
// Grants exclusive ownership via req/gnt, inserts a guard gap of idle pads
// after every release and asks a long-holding owner to yield under contention.
// Build option QSPI_ARB_RR_EN: round-robin tie breaking instead of fixed
// priority to requester 0.
module qspi_bus_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned MAX_HOLD     = 64,
  parameter int unsigned HOLD_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            req1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            yield0,
  output logic            yield1,
  input  logic            ce0_n_i,
  input  logic            ce1_n_i,
  input  logic            sclk0_i,
  input  logic            sclk1_i,
  input  logic [IO_W-1:0] io0_out_i,
  input  logic [IO_W-1:0] io1_out_i,
  input  logic [IO_W-1:0] io0_oe_i,
  input  logic [IO_W-1:0] io1_oe_i,
  output logic [IO_W-1:0] io0_in_o,
  output logic [IO_W-1:0] io1_in_o,
  output logic            pad_ce0_n,
  output logic            pad_ce1_n,
  output logic            pad_sclk,
  output logic [IO_W-1:0] pad_io_out,
  output logic [IO_W-1:0] pad_io_oe,
  input  logic [IO_W-1:0] pad_io_in,
  output logic            busy,
  output logic            owner
);

  localparam int unsigned        GUARD_W    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(MAX_HOLD);
  localparam logic               YIELD_EN   = (MAX_HOLD != 0);

  arb_state_e         state_q, state_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               yield0_q, yield0_d;
  logic               yield1_q, yield1_d;
  logic               owner_q, owner_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [GUARD_W-1:0] guard_q, guard_d;

  logic prefer1;
  logic win;
  logic owner_req;
  logic other_req;

  qspi_pins_t pins0;
  qspi_pins_t pins1;

`ifdef QSPI_ARB_RR_EN
  logic last_q, last_d;

  // A tie goes to whoever did not own the bus last.
  assign prefer1 = (last_q == OWNER_FLASH);
`else
  assign prefer1 = 1'b0;
`endif

  assign win       = arb_winner(req0, req1, prefer1);
  assign owner_req = (owner_q == OWNER_PSRAM) ? req1 : req0;
  assign other_req = (owner_q == OWNER_PSRAM) ? req0 : req1;

  // Next-state, grant, yield and counter logic.
  always_comb begin
    state_d  = state_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    yield0_d = yield0_q;
    yield1_d = yield1_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    guard_d  = guard_q;
`ifdef QSPI_ARB_RR_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        if (req0 || req1) begin
          state_d = ST_OWN;
          owner_d = win;
          gnt0_d  = (win == OWNER_FLASH);
          gnt1_d  = (win == OWNER_PSRAM);
`ifdef QSPI_ARB_RR_EN
          last_d  = win;
`endif
        end
      end
      ST_OWN: begin
        if (!owner_req) begin
          gnt0_d   = 1'b0;
          gnt1_d   = 1'b0;
          yield0_d = 1'b0;
          yield1_d = 1'b0;
          hold_d   = '0;
          if (GUARD_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GUARD;
            guard_d = GUARD_LOAD;
          end
        end else begin
          if (!other_req) begin
            hold_d = '0;
          end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
          end
          // Yield is sticky until the owner releases; no forced preemption.
          if (YIELD_EN && (hold_q == HOLD_MAX)) begin
            if (owner_q == OWNER_FLASH) begin
              yield0_d = 1'b1;
            end else begin
              yield1_d = 1'b1;
            end
          end
        end
      end
      ST_GUARD: begin
        if (guard_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q - GUARD_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        yield0_d = 1'b0;
        yield1_d = 1'b0;
        hold_d   = '0;
        guard_d  = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      yield0_q <= 1'b0;
      yield1_q <= 1'b0;
      owner_q  <= OWNER_FLASH;
      hold_q   <= '0;
      guard_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      yield0_q <= yield0_d;
      yield1_q <= yield1_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      guard_q  <= guard_d;
    end
  end

`ifdef QSPI_ARB_RR_EN
  // Last-owner register; resets to PSRAM so flash wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWNER_PSRAM;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign yield0 = yield0_q;
  assign yield1 = yield1_q;
  assign owner  = owner_q;
  assign busy   = (state_q != ST_IDLE);

  assign pins0 = '{ce_n: ce0_n_i, sclk: sclk0_i, io_out: io0_out_i, io_oe: io0_oe_i};
  assign pins1 = '{ce_n: ce1_n_i, sclk: sclk1_i, io_out: io1_out_i, io_oe: io1_oe_i};

  qspi_pad_mux u_pad_mux (
    .active_i     (state_q == ST_OWN),
    .owner_i      (owner_q),
    .req0_i       (req0),
    .req1_i       (req1),
    .pins0_i      (pins0),
    .pins1_i      (pins1),
    .pad_io_in_i  (pad_io_in),
    .pad_ce0_n_o  (pad_ce0_n),
    .pad_ce1_n_o  (pad_ce1_n),
    .pad_sclk_o   (pad_sclk),
    .pad_io_out_o (pad_io_out),
    .pad_io_oe_o  (pad_io_oe),
    .io0_in_o     (io0_in_o),
    .io1_in_o     (io1_in_o)
  );

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Testbench for qspi_bus_arbiter: directed scenarios plus a randomized run
// against a cycle-level ownership model. A second instance is built with
// GUARD_CYCLES=0.
`timescale 1ns/1ps
module tb_qspi_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, g_req0, g_req1;
  logic       ce0_n_i, ce1_n_i, sclk0_i, sclk1_i;
  logic [3:0] io0_out_i, io1_out_i, io0_oe_i, io1_oe_i, pad_io_in;

  logic       gnt0, gnt1, yield0, yield1, busy, owner;
  logic       pad_ce0_n, pad_ce1_n, pad_sclk;
  logic [3:0] pad_io_out, pad_io_oe, io0_in_o, io1_in_o;

  logic       g_gnt0, g_gnt1, g_yield0, g_yield1, g_busy, g_owner;
  logic       g_pad_ce0_n, g_pad_ce1_n, g_pad_sclk;
  logic [3:0] g_pad_io_out, g_pad_io_oe, g_io0_in_o, g_io1_in_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state (random test only).
  int m_owner, m_free_at, m_cyc, m_streak, m_last;
  bit m_yield;

  localparam int G_CYC = 2;
  localparam int MAXH  = 64;

  always #5 clk = ~clk;

  qspi_bus_arbiter #(.GUARD_CYCLES(2), .MAX_HOLD(64), .HOLD_W(8)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .yield0(yield0), .yield1(yield1), .ce0_n_i(ce0_n_i), .ce1_n_i(ce1_n_i),
    .sclk0_i(sclk0_i), .sclk1_i(sclk1_i), .io0_out_i(io0_out_i), .io1_out_i(io1_out_i),
    .io0_oe_i(io0_oe_i), .io1_oe_i(io1_oe_i), .io0_in_o(io0_in_o), .io1_in_o(io1_in_o),
    .pad_ce0_n(pad_ce0_n), .pad_ce1_n(pad_ce1_n), .pad_sclk(pad_sclk),
    .pad_io_out(pad_io_out), .pad_io_oe(pad_io_oe), .pad_io_in(pad_io_in),
    .busy(busy), .owner(owner)
  );

  qspi_bus_arbiter #(.GUARD_CYCLES(0), .MAX_HOLD(64), .HOLD_W(8)) u_dut_g0 (
    .clk(clk), .rst(rst), .req0(g_req0), .req1(g_req1), .gnt0(g_gnt0), .gnt1(g_gnt1),
    .yield0(g_yield0), .yield1(g_yield1), .ce0_n_i(ce0_n_i), .ce1_n_i(ce1_n_i),
    .sclk0_i(sclk0_i), .sclk1_i(sclk1_i), .io0_out_i(io0_out_i), .io1_out_i(io1_out_i),
    .io0_oe_i(io0_oe_i), .io1_oe_i(io1_oe_i), .io0_in_o(g_io0_in_o), .io1_in_o(g_io1_in_o),
    .pad_ce0_n(g_pad_ce0_n), .pad_ce1_n(g_pad_ce1_n), .pad_sclk(g_pad_sclk),
    .pad_io_out(g_pad_io_out), .pad_io_oe(g_pad_io_oe), .pad_io_in(pad_io_in),
    .busy(g_busy), .owner(g_owner)
  );

  // Grant mutual exclusion on both instances, every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((gnt0 && gnt1) || (g_gnt0 && g_gnt1)) begin
        failures++;
        $display("FAIL mutex t=%0t gnt=%b%b g_gnt=%b%b required at most one", $time, gnt0, gnt1, g_gnt0, g_gnt1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; g_req0 = 1'b0; g_req1 = 1'b0;
    ce0_n_i = 1'b1; ce1_n_i = 1'b1; sclk0_i = 1'b0; sclk1_i = 1'b0;
    io0_out_i = 4'h0; io1_out_i = 4'h0; io0_oe_i = 4'h0; io1_oe_i = 4'h0; pad_io_in = 4'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    sclk0_i = 1'b1; io0_out_i = 4'hF; io0_oe_i = 4'hF; ce0_n_i = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, yield0, yield1, busy, owner} !== 6'b0) begin
      failures++;
      $display("FAIL reset_regs got=%b required=000000", {gnt0, gnt1, yield0, yield1, busy, owner});
    end
    checks++;
    if ({pad_ce0_n, pad_ce1_n, pad_sclk, pad_io_out, pad_io_oe} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_pads got=%b required=11000000000", {pad_ce0_n, pad_ce1_n, pad_sclk, pad_io_out, pad_io_oe});
    end
    tick();
    rst = 1'b0;
    req0 = 1'b1;
    tick();
    checks++;
    if (gnt0 !== 1'b1 || pad_ce0_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_pre_own gnt0=%b pad_ce0_n=%b required 1/0", gnt0, pad_ce0_n);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({pad_ce0_n, pad_sclk, pad_io_oe, gnt0, busy} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_async got=%b required=10000000", {pad_ce0_n, pad_sclk, pad_io_oe, gnt0, busy});
    end
    tick();
    do_reset();
  endtask

  task automatic test_single_grant();
    do_reset();
    ce1_n_i = 1'b0; sclk1_i = 1'b0; io1_out_i = 4'h5; io1_oe_i = 4'h3;
    req0 = 1'b1;
    #1;
    checks++;
    if (gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL gnt_latency_pre gnt0=%b required=0", gnt0);
    end
    tick();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || owner !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL gnt_latency gnt=%b%b owner=%b busy=%b required 10/0/1", gnt0, gnt1, owner, busy);
    end
    io0_oe_i = 4'hF; io0_out_i = 4'hA; ce0_n_i = 1'b0; sclk0_i = 1'b1; pad_io_in = 4'h7;
    #1;
    checks++;
    if ({pad_io_oe, pad_io_out, pad_ce0_n, pad_ce1_n, pad_sclk, io0_in_o, io1_in_o} !==
        {4'hF, 4'hA, 1'b0, 1'b1, 1'b1, 4'h7, 4'h0}) begin
      failures++;
      $display("FAIL flash_pads oe=%h out=%h ce=%b%b sclk=%b in0=%h in1=%h required F A 01 1 7 0",
               pad_io_oe, pad_io_out, pad_ce0_n, pad_ce1_n, pad_sclk, io0_in_o, io1_in_o);
    end
    req0 = 1'b0;
    #1;
    checks++;
    if (pad_ce0_n !== 1'b1) begin
      failures++;
      $display("FAIL ce_gate pad_ce0_n=%b required=1", pad_ce0_n);
    end
    ce0_n_i = 1'b1;
    tick();
    checks++;
    if (gnt0 !== 1'b0 || busy !== 1'b1 || pad_io_oe !== 4'h0 || pad_sclk !== 1'b0) begin
      failures++;
      $display("FAIL guard_enter gnt0=%b busy=%b oe=%h sclk=%b required 0 1 0 0", gnt0, busy, pad_io_oe, pad_sclk);
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL guard_hold busy=%b required=1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL guard_exit busy=%b required=0", busy);
    end
  endtask

  task automatic test_tie_guard();
    int  k;
    bit  exp1;
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL tie_first gnt=%b%b required=10", gnt0, gnt1);
    end
    req0 = 1'b0; io1_oe_i = 4'hF; sclk1_i = 1'b1;
    tick();
    k = 0;
    checks++;
    if (pad_io_oe !== 4'h0 || pad_sclk !== 1'b0 || gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL tie_guard_pads oe=%h sclk=%b gnt0=%b required 0 0 0", pad_io_oe, pad_sclk, gnt0);
    end
    while (!gnt1 && k < 20) begin tick(); k++; end
    checks++;
    if (k !== 3) begin
      failures++;
      $display("FAIL tie_release_to_gnt1 cycles=%0d required=3", k);
    end
    // PSRAM releases and both requesters compete again.
    req0 = 1'b1; req1 = 1'b0;
    tick();
    req1 = 1'b1;
    k = 0;
    while (!(gnt0 || gnt1) && k < 20) begin tick(); k++; end
    checks++;
    if (k !== 3 || gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL tie_after_psram cycles=%0d gnt=%b%b required 3 cycles gnt=10", k, gnt0, gnt1);
    end
    // Flash releases and re-raises during guard.
    req0 = 1'b0;
    tick();
    req0 = 1'b1;
    k = 0;
    while (!(gnt0 || gnt1) && k < 20) begin tick(); k++; end
`ifdef QSPI_ARB_RR_EN
    exp1 = 1'b1;
`else
    exp1 = 1'b0;
`endif
    checks++;
    if (k !== 3 || gnt1 !== exp1 || gnt0 !== !exp1) begin
      failures++;
      $display("FAIL tie_after_flash cycles=%0d gnt=%b%b required 3 cycles gnt1=%b", k, gnt0, gnt1, exp1);
    end
  endtask

  task automatic test_yield();
    int k;
    do_reset();
    req0 = 1'b1;
    tick();
    req1 = 1'b1;
    k = 0;
    while (!yield0 && k < 100) begin tick(); k++; end
    checks++;
    if (k !== 65) begin
      failures++;
      $display("FAIL yield_edges edges=%0d required=65", k);
    end
    tick(); tick();
    checks++;
    if (yield0 !== 1'b1 || yield1 !== 1'b0 || gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL yield_sticky yield=%b%b gnt0=%b required 10 1", yield0, yield1, gnt0);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (yield0 !== 1'b0 || gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL yield_clear yield0=%b gnt0=%b required 0 0", yield0, gnt0);
    end
    k = 0;
    while (!gnt1 && k < 20) begin tick(); k++; end
    checks++;
    if (k !== 3) begin
      failures++;
      $display("FAIL yield_handover cycles=%0d required=3", k);
    end
  endtask

  task automatic test_psram_read();
    do_reset();
    req1 = 1'b1;
    tick();
    checks++;
    if (gnt1 !== 1'b1 || owner !== 1'b1) begin
      failures++;
      $display("FAIL psram_gnt gnt1=%b owner=%b required 1 1", gnt1, owner);
    end
    pad_io_in = 4'h5; ce1_n_i = 1'b0; ce0_n_i = 1'b0; sclk1_i = 1'b1;
    #1;
    checks++;
    if ({io1_in_o, io0_in_o, pad_ce1_n, pad_ce0_n, pad_sclk} !== {4'h5, 4'h0, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL psram_read in1=%h in0=%h ce1=%b ce0=%b sclk=%b required 5 0 0 1 1",
               io1_in_o, io0_in_o, pad_ce1_n, pad_ce0_n, pad_sclk);
    end
    ce1_n_i = 1'b1;
    #1;
    checks++;
    if (pad_ce1_n !== 1'b1) begin
      failures++;
      $display("FAIL psram_ce_track pad_ce1_n=%b required=1", pad_ce1_n);
    end
  endtask

  task automatic test_guard0();
    do_reset();
    g_req0 = 1'b1; g_req1 = 1'b1;
    tick();
    checks++;
    if (g_gnt0 !== 1'b1 || g_gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL g0_first gnt=%b%b required=10", g_gnt0, g_gnt1);
    end
    g_req0 = 1'b0;
    tick();
    checks++;
    if (g_gnt0 !== 1'b0 || g_gnt1 !== 1'b0 || g_busy !== 1'b0) begin
      failures++;
      $display("FAIL g0_release gnt=%b%b busy=%b required 00 0", g_gnt0, g_gnt1, g_busy);
    end
    tick();
    checks++;
    if (g_gnt1 !== 1'b1) begin
      failures++;
      $display("FAIL g0_handover gnt1=%b required=1", g_gnt1);
    end
  endtask

  task automatic test_random();
    int         w;
    bit         own_r, oth_r, exp_busy;
    logic [18:0] exp_p, act_p;
    do_reset();
    m_owner = -1; m_free_at = 0; m_cyc = 0; m_streak = 0; m_yield = 1'b0; m_last = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 99) < 3) req0 = ~req0;
      if ($urandom_range(0, 99) < 3) req1 = ~req1;
      if ($urandom_range(0, 99) < 20) g_req0 = ~g_req0;
      if ($urandom_range(0, 99) < 20) g_req1 = ~g_req1;
      ce0_n_i = 1'($urandom); ce1_n_i = 1'($urandom);
      sclk0_i = 1'($urandom); sclk1_i = 1'($urandom);
      io0_out_i = 4'($urandom); io1_out_i = 4'($urandom);
      io0_oe_i = 4'($urandom); io1_oe_i = 4'($urandom);
      pad_io_in = 4'($urandom);
      // Ownership model evaluated at the coming edge.
      if (m_owner < 0) begin
        if (m_cyc >= m_free_at && (req0 || req1)) begin
          if (req0 && req1) begin
`ifdef QSPI_ARB_RR_EN
            w = (m_last == 1) ? 0 : 1;
`else
            w = 0;
`endif
          end else begin
            w = req1 ? 1 : 0;
          end
          m_owner = w; m_last = w; m_streak = 0; m_yield = 1'b0;
        end
      end else begin
        own_r = (m_owner == 0) ? req0 : req1;
        oth_r = (m_owner == 0) ? req1 : req0;
        if (!own_r) begin
          m_owner = -1; m_yield = 1'b0; m_free_at = m_cyc + G_CYC + 1;
        end else begin
          if (MAXH != 0 && m_streak >= MAXH) m_yield = 1'b1;
          m_streak = oth_r ? m_streak + 1 : 0;
        end
      end
      tick();
      exp_busy = (m_owner >= 0) || (m_cyc + 1 < m_free_at);
      checks++;
      if (gnt0 !== (m_owner == 0) || gnt1 !== (m_owner == 1)) begin
        failures++;
        $display("FAIL rnd_gnt cyc=%0d got=%b%b model_owner=%0d", m_cyc, gnt0, gnt1, m_owner);
      end
      checks++;
      if (yield0 !== (m_yield && m_owner == 0) || yield1 !== (m_yield && m_owner == 1)) begin
        failures++;
        $display("FAIL rnd_yield cyc=%0d got=%b%b model_yield=%b owner=%0d", m_cyc, yield0, yield1, m_yield, m_owner);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL rnd_busy cyc=%0d got=%b required=%b", m_cyc, busy, exp_busy);
      end
      if (m_owner >= 0) begin
        checks++;
        if (owner !== 1'(m_owner)) begin
          failures++;
          $display("FAIL rnd_owner cyc=%0d got=%b required=%0d", m_cyc, owner, m_owner);
        end
      end
      if (m_owner == 0)
        exp_p = {ce0_n_i | ~req0, 1'b1, sclk0_i, io0_out_i, io0_oe_i, pad_io_in, 4'h0};
      else if (m_owner == 1)
        exp_p = {1'b1, ce1_n_i | ~req1, sclk1_i, io1_out_i, io1_oe_i, 4'h0, pad_io_in};
      else
        exp_p = {1'b1, 1'b1, 17'h0};
      act_p = {pad_ce0_n, pad_ce1_n, pad_sclk, pad_io_out, pad_io_oe, io0_in_o, io1_in_o};
      checks++;
      if (act_p !== exp_p) begin
        failures++;
        $display("FAIL rnd_pads cyc=%0d got=%h required=%h", m_cyc, act_p, exp_p);
      end
      m_cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_tie_guard();
    test_yield();
    test_psram_read();
    test_guard0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
